// File: rtl/video_mnist_pkg.sv
// video_mnist_pkg: register word addresses, class count default and control/status bit positions
package video_mnist_pkg;
   localparam int NUM_CLASSES_DEF = 10;
   localparam int ADR_CTRL        = 'h00;
   localparam int ADR_STATUS      = 'h01;
   localparam int ADR_THRESHOLD   = 'h02;
   localparam int ADR_FRAME_COUNT = 'h03;
   localparam int ADR_HIST_BASE   = 'h10;
   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int STATUS_DONE_BIT = 0;
endpackage

// File: rtl/video_mnist_hist_bin.sv
// video_mnist_hist_bin: one saturating histogram bin with a frame snapshot register
//  aclk, aresetn    clock, asynchronous active-low reset
//  inc              count one pixel
//  clear            restart the bin; an inc in the same cycle lands in the fresh bin
//  snapshot         copy the running count (taken before clear in the same cycle)
//  snap_o           last snapshot
module video_mnist_hist_bin #(
   parameter int HIST_WIDTH = 20
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  inc,
   input  logic                  clear,
   input  logic                  snapshot,
   output logic [HIST_WIDTH-1:0] snap_o
);
   logic [HIST_WIDTH-1:0] cnt_q, cnt_d, snap_q, snap_d;
   always_comb begin
      snap_d = snapshot ? cnt_q : snap_q;
      cnt_d  = clear ? HIST_WIDTH'(inc) : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q  <= '0;
         snap_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         snap_q <= snap_d;
      end
   end
   assign snap_o = snap_q;
endmodule

// File: rtl/video_mnist_number_hist.sv
// video_mnist_number_hist: classified-stream pass-through with per-frame digit histograms readable over Wishbone
//  aresetn, aclk           asynchronous active-low reset, single clock
//  s_axi4s_*               classified pixel stream in (tuser[0] = SOF)
//  m_axi4s_*               registered copy of the input stream
//  s_wb_*                  zero-wait-state Wishbone slave (word addresses)
//  irq                     done & irq_enable, only with VIDEO_MNIST_NUMBER_HIST_IRQ_EN defined
module video_mnist_number_hist
   import video_mnist_pkg::*;
#(
   parameter int       TUSER_WIDTH       = 1,
   parameter int       TNUMBER_WIDTH     = 4,
   parameter int       TCOUNT_WIDTH      = 4,
   parameter int       NUM_CLASSES       = NUM_CLASSES_DEF,
   parameter int       HIST_WIDTH        = 20,
   parameter int       WB_ADR_WIDTH      = 8,
   parameter int       WB_DAT_WIDTH      = 32,
   parameter int       WB_SEL_WIDTH      = WB_DAT_WIDTH / 8,
   parameter bit       INIT_PARAM_ENABLE = 1'b1,
   parameter int       INIT_PARAM_TH     = 7
) (
   input  logic                     aresetn,
   input  logic                     aclk,
   input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
   input  logic                     s_axi4s_tlast,
   input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
   input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
   input  logic                     s_axi4s_tvalid,
   output logic                     s_axi4s_tready,
   output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
   output logic                     m_axi4s_tlast,
   output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
   output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
   output logic                     m_axi4s_tvalid,
   input  logic                     m_axi4s_tready,
   input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
   input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
   output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
   input  logic                     s_wb_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
   input  logic                     s_wb_stb_i,
   output logic                     s_wb_ack_o
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
  ,output logic                     irq
`endif
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [WB_ADR_WIDTH-1:0] A_CTRL   = WB_ADR_WIDTH'(ADR_CTRL);
   localparam logic [WB_ADR_WIDTH-1:0] A_STATUS = WB_ADR_WIDTH'(ADR_STATUS);
   localparam logic [WB_ADR_WIDTH-1:0] A_TH     = WB_ADR_WIDTH'(ADR_THRESHOLD);
   localparam logic [WB_ADR_WIDTH-1:0] A_FC     = WB_ADR_WIDTH'(ADR_FRAME_COUNT);

   logic [TUSER_WIDTH-1:0]   m_tuser_q, m_tuser_d;
   logic                     m_tlast_q, m_tlast_d;
   logic [TNUMBER_WIDTH-1:0] m_tnumber_q, m_tnumber_d;
   logic [TCOUNT_WIDTH-1:0]  m_tcount_q, m_tcount_d;
   logic                     m_tvalid_q, m_tvalid_d;
   logic [0:0]               state_q, state_d;
   logic [TCOUNT_WIDTH-1:0]  th_act_q, th_act_d;
   logic                     ctrl_en_q, ctrl_en_d;
   logic [TCOUNT_WIDTH-1:0]  th_q, th_d;
   logic                     done_q, done_d;
   logic [WB_DAT_WIDTH-1:0]  fc_q, fc_d;
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
   logic                     irq_en_q, irq_en_d;
`endif

   logic                     accept, sof, snap, count_en, hit;
   logic [TCOUNT_WIDTH-1:0]  th_use;
   logic [NUM_CLASSES-1:0]   inc;
   logic [HIST_WIDTH-1:0]    snap_w [NUM_CLASSES];
   logic [WB_DAT_WIDTH-1:0]  wmask, rdata;
   logic                     wr, wr_ctrl, wr_status, wr_th;
   logic                     unused_ok;

   assign s_axi4s_tready = !m_tvalid_q || m_axi4s_tready;
   assign accept         = s_axi4s_tvalid && s_axi4s_tready;
   assign sof            = accept && s_axi4s_tuser[0];

   // Stream register stage: only loads when the downstream slot is free.
   always_comb begin
      m_tuser_d   = s_axi4s_tready ? s_axi4s_tuser   : m_tuser_q;
      m_tlast_d   = s_axi4s_tready ? s_axi4s_tlast   : m_tlast_q;
      m_tnumber_d = s_axi4s_tready ? s_axi4s_tnumber : m_tnumber_q;
      m_tcount_d  = s_axi4s_tready ? s_axi4s_tcount  : m_tcount_q;
      m_tvalid_d  = s_axi4s_tready ? s_axi4s_tvalid  : m_tvalid_q;
   end

   // The SOF beat belongs to the new frame, so it is judged with the freshly
   // shadowed threshold and enable rather than the previous frame's.
   always_comb begin
      state_d  = sof ? (ctrl_en_q ? ST_RUN : ST_IDLE) : state_q;
      th_act_d = sof ? th_q : th_act_q;
      th_use   = sof ? th_q : th_act_q;
      snap     = sof && (state_q == ST_RUN);
      count_en = accept && (sof ? ctrl_en_q : (state_q == ST_RUN));
      hit      = count_en && (s_axi4s_tcount >= th_use) && (int'(s_axi4s_tnumber) < NUM_CLASSES);
   end

   for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_bin
      assign inc[g] = hit && (s_axi4s_tnumber == TNUMBER_WIDTH'(g));
      video_mnist_hist_bin #(.HIST_WIDTH(HIST_WIDTH)) u_bin (
         .aclk     (aclk),
         .aresetn  (aresetn),
         .inc      (inc[g]),
         .clear    (sof),
         .snapshot (snap),
         .snap_o   (snap_w[g])
      );
   end

   always_comb begin
      wmask = '0;
      for (int b = 0; b < WB_SEL_WIDTH; b++) wmask[b*8 +: 8] = {8{s_wb_sel_i[b]}};
   end

   assign wr        = s_wb_stb_i && s_wb_we_i;
   assign wr_ctrl   = wr && (s_wb_adr_i == A_CTRL) && s_wb_sel_i[0];
   assign wr_status = wr && (s_wb_adr_i == A_STATUS) && s_wb_sel_i[0];
   assign wr_th     = wr && (s_wb_adr_i == A_TH);

   // A snapshot in the same cycle as a W1C clear of done keeps done set.
   always_comb begin
      ctrl_en_d = wr_ctrl ? s_wb_dat_i[CTRL_ENABLE_BIT] : ctrl_en_q;
      th_d      = wr_th ? (th_q & ~wmask[TCOUNT_WIDTH-1:0]) | (s_wb_dat_i[TCOUNT_WIDTH-1:0] & wmask[TCOUNT_WIDTH-1:0]) : th_q;
      done_d    = snap ? 1'b1 : (wr_status && s_wb_dat_i[STATUS_DONE_BIT]) ? 1'b0 : done_q;
      fc_d      = fc_q + WB_DAT_WIDTH'(snap);
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
      irq_en_d  = wr_ctrl ? s_wb_dat_i[CTRL_IRQ_EN_BIT] : irq_en_q;
`endif
   end

   always_comb begin
      rdata = '0;
      if (s_wb_adr_i == A_CTRL) begin
         rdata[CTRL_ENABLE_BIT] = ctrl_en_q;
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
         rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
`endif
      end
      if (s_wb_adr_i == A_STATUS) rdata[STATUS_DONE_BIT] = done_q;
      if (s_wb_adr_i == A_TH) rdata[TCOUNT_WIDTH-1:0] = th_q;
      if (s_wb_adr_i == A_FC) rdata = fc_q;
      for (int i = 0; i < NUM_CLASSES; i++)
         if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_HIST_BASE + i)) rdata = WB_DAT_WIDTH'(snap_w[i]);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_tuser_q   <= '0;
         m_tlast_q   <= 1'b0;
         m_tnumber_q <= '0;
         m_tcount_q  <= '0;
         m_tvalid_q  <= 1'b0;
         state_q     <= ST_IDLE;
         th_act_q    <= TCOUNT_WIDTH'(INIT_PARAM_TH);
         ctrl_en_q   <= INIT_PARAM_ENABLE;
         th_q        <= TCOUNT_WIDTH'(INIT_PARAM_TH);
         done_q      <= 1'b0;
         fc_q        <= '0;
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
         irq_en_q    <= 1'b0;
`endif
      end else begin
         m_tuser_q   <= m_tuser_d;
         m_tlast_q   <= m_tlast_d;
         m_tnumber_q <= m_tnumber_d;
         m_tcount_q  <= m_tcount_d;
         m_tvalid_q  <= m_tvalid_d;
         state_q     <= state_d;
         th_act_q    <= th_act_d;
         ctrl_en_q   <= ctrl_en_d;
         th_q        <= th_d;
         done_q      <= done_d;
         fc_q        <= fc_d;
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
         irq_en_q    <= irq_en_d;
`endif
      end
   end

   assign m_axi4s_tuser   = m_tuser_q;
   assign m_axi4s_tlast   = m_tlast_q;
   assign m_axi4s_tnumber = m_tnumber_q;
   assign m_axi4s_tcount  = m_tcount_q;
   assign m_axi4s_tvalid  = m_tvalid_q;
   assign s_wb_ack_o      = s_wb_stb_i;
   assign s_wb_dat_o      = s_wb_stb_i ? rdata : '0;
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
   assign irq             = done_q && irq_en_q;
`endif
   // Upper data/select bits and extra tuser bits have no register behind them.
   assign unused_ok = ^{s_wb_dat_i, wmask, s_wb_sel_i, s_axi4s_tuser};
endmodule

// File: tb/tb_video_mnist_number_hist.sv
// tb_video_mnist_number_hist: scoreboard bench with a frame-level histogram model
module tb_video_mnist_number_hist;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [0:0]  s_axi4s_tuser = '0;
   logic        s_axi4s_tlast = 1'b0;
   logic [3:0]  s_axi4s_tnumber = '0;
   logic [3:0]  s_axi4s_tcount = '0;
   logic        s_axi4s_tvalid = 1'b0;
   logic        s_axi4s_tready;
   logic [0:0]  m_axi4s_tuser;
   logic        m_axi4s_tlast;
   logic [3:0]  m_axi4s_tnumber;
   logic [3:0]  m_axi4s_tcount;
   logic        m_axi4s_tvalid;
   logic        m_axi4s_tready = 1'b1;
   logic [7:0]  s_wb_adr_i = '0;
   logic [31:0] s_wb_dat_i = '0;
   logic [31:0] s_wb_dat_o;
   logic        s_wb_we_i = 1'b0;
   logic [3:0]  s_wb_sel_i = '0;
   logic        s_wb_stb_i = 1'b0;
   logic        s_wb_ack_o;
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
   logic        irq;
`endif

   video_mnist_number_hist dut (
      .aresetn(aresetn), .aclk(aclk),
      .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
      .s_axi4s_tnumber(s_axi4s_tnumber), .s_axi4s_tcount(s_axi4s_tcount),
      .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
      .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
      .m_axi4s_tnumber(m_axi4s_tnumber), .m_axi4s_tcount(m_axi4s_tcount),
      .m_axi4s_tvalid(m_axi4s_tvalid), .m_axi4s_tready(m_axi4s_tready),
      .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
      .s_wb_we_i(s_wb_we_i), .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i),
      .s_wb_ack_o(s_wb_ack_o)
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
     ,.irq(irq)
`endif
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic       user;
      logic       last;
      logic [3:0] num;
      logic [3:0] cnt;
   } beat_t;

   int total = 0;
   int bad = 0;
   beat_t exp_q[$];
   logic [31:0] rd_exp_q[$];
   int rd_adr_q[$];
   bit rnd_ready = 0;

   // Reference model: the histogram of the frame in progress, the last frame's
   // snapshot and the register file, all in plain integers.
   int m_bins[10];
   int m_snap[10];
   int unsigned m_fc;
   bit m_done, m_run, m_en, m_irq_en;
   int m_th, m_th_act;

   task automatic model_reset();
      foreach (m_bins[i]) begin m_bins[i] = 0; m_snap[i] = 0; end
      m_fc = 0; m_done = 0; m_run = 0; m_en = 1; m_irq_en = 0; m_th = 7; m_th_act = 7;
   endtask

   task automatic model_beat(input beat_t b);
      if (b.user) begin
         if (m_run) begin
            m_snap = m_bins;
            m_fc++;
            m_done = 1;
         end
         m_th_act = m_th;
         m_run = m_en;
         foreach (m_bins[i]) m_bins[i] = 0;
      end
      if (m_run && int'(b.num) < 10 && int'(b.cnt) >= m_th_act && m_bins[b.num] < (1 << 20) - 1)
         m_bins[b.num]++;
   endtask

   function automatic logic [31:0] model_read(input int adr);
      if (adr == 0) return {30'd0, m_irq_en, m_en};
      if (adr == 1) return {31'd0, m_done};
      if (adr == 2) return 32'(m_th);
      if (adr == 3) return m_fc;
      if (adr >= 'h10 && adr < 'h1A) return 32'(m_snap[adr - 'h10]);
      return 32'd0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Handshakes are decided by levels that are stable between the drive point
   // (posedge+1) and the next posedge, so sampling at negedge sees the transfer.
   always @(negedge aclk) begin
      if (aresetn && m_axi4s_tvalid && m_axi4s_tready) begin
         if (exp_q.size() == 0) check("stream_extra_beat", 32'd1, 32'd0);
         else begin
            beat_t e;
            e = exp_q.pop_front();
            check("stream_beat", {22'd0, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount}, {22'd0, e});
         end
      end
      if (aresetn && s_axi4s_tvalid && s_axi4s_tready) begin
         beat_t b;
         b = {s_axi4s_tuser[0], s_axi4s_tlast, s_axi4s_tnumber, s_axi4s_tcount};
         exp_q.push_back(b);
         model_beat(b);
      end
      if (s_wb_stb_i && !s_wb_we_i && rd_exp_q.size() > 0) begin
         int a;
         a = rd_adr_q.pop_front();
         check($sformatf("wb_read_%02h", a), s_wb_dat_o, rd_exp_q.pop_front());
         check("wb_ack", {31'd0, s_wb_ack_o}, 32'd1);
      end
   end

   always @(posedge aclk) begin
      #1;
      m_axi4s_tready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
   end

   task automatic send_beat(input logic user, input logic last, input logic [3:0] num, input logic [3:0] cnt);
      int n;
      s_axi4s_tuser = user; s_axi4s_tlast = last; s_axi4s_tnumber = num; s_axi4s_tcount = cnt;
      s_axi4s_tvalid = 1'b1;
      n = 0;
      forever begin
         @(negedge aclk);
         if (s_axi4s_tready) break;
         if (++n > 200) begin
            total++; bad++;
            $display("FAIL s_tready_timeout: stuck low for %0d cycles", n);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "stream stalled");
         end
      end
      @(posedge aclk); #1;
      s_axi4s_tvalid = 1'b0;
   endtask

   task automatic wb_write(input int adr, input logic [31:0] dat, input logic [3:0] sel);
      s_wb_adr_i = 8'(adr); s_wb_dat_i = dat; s_wb_sel_i = sel; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
      if (adr == 0 && sel[0]) begin
         m_en = dat[0];
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
         m_irq_en = dat[1];
`endif
      end
      if (adr == 1 && sel[0] && dat[0]) m_done = 0;
      if (adr == 2 && sel[0]) m_th = int'(dat[3:0]);
      @(posedge aclk); #1;
      s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0;
   endtask

   task automatic wb_read(input int adr);
      rd_exp_q.push_back(model_read(adr));
      rd_adr_q.push_back(adr);
      s_wb_adr_i = 8'(adr); s_wb_we_i = 1'b0; s_wb_sel_i = 4'hF; s_wb_stb_i = 1'b1;
      @(posedge aclk); #1;
      s_wb_stb_i = 1'b0;
   endtask

   task automatic read_all();
      foreach (m_bins[i]) wb_read('h10 + i);
      for (int a = 0; a < 4; a++) wb_read(a);
      wb_read('h05);
      wb_read('h1A);
`ifdef VIDEO_MNIST_NUMBER_HIST_IRQ_EN
      check("irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
`endif
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      #2;
      check("rst_m_tvalid", {31'd0, m_axi4s_tvalid}, 32'd0);
      model_reset();
      exp_q.delete();
      @(posedge aclk); #1;
      check("rst_m_data", {22'd0, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount}, 32'd0);
      check("rst_wb_dat_o", s_wb_dat_o, 32'd0);
      aresetn = 1'b1;
   endtask

   // mode 0: digit 3 @ conf 9; 1: digit 3 @ conf 7/6; 2: digit 12; 3: random.
   task automatic frame(input int w, input int h, input int mode, input bit mid_th, input int abort_at);
      int idx;
      logic [3:0] num, cnt;
      idx = 0;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            if (idx == abort_at) begin do_reset(); return; end
            if (mid_th && y == h / 2 && x == 0) wb_write(2, 32'd15, 4'h1);
            num = mode == 3 ? 4'($urandom_range(0, 15)) : (mode == 2 ? 4'd12 : 4'd3);
            cnt = mode == 0 ? 4'd9 : mode == 1 ? ((idx % 2 == 0) ? 4'd7 : 4'd6) : 4'($urandom_range(0, 15));
            send_beat(x == 0 && y == 0, x == w - 1, num, cnt);
            idx++;
         end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge aclk);
      #1;
      check("reset_m_tvalid", {31'd0, m_axi4s_tvalid}, 32'd0);
      check("reset_m_data", {22'd0, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount}, 32'd0);
      check("reset_wb_dat_o", s_wb_dat_o, 32'd0);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      read_all();
      frame(4, 2, 0, 0, -1);
      frame(4, 2, 1, 0, -1);
      read_all();
      wb_write(1, 32'd1, 4'h1);
      wb_read(1);
      frame(4, 2, 2, 0, -1);
      read_all();
      frame(4, 2, 3, 0, -1);
      read_all();
      rnd_ready = 1;
      frame(8, 4, 3, 1, -1);
      frame(8, 4, 3, 0, -1);
      read_all();
      frame(8, 4, 0, 0, -1);
      read_all();
      wb_write(2, 32'd7, 4'h1);
      wb_write(2, 32'd15, 4'h2);
      wb_write('h13, 32'hFFFF, 4'hF);
      wb_write('h05, 32'hFFFF, 4'hF);
      wb_write(0, 32'd0, 4'h0);
      frame(6, 3, 3, 0, -1);
      frame(6, 3, 3, 0, -1);
      read_all();
      wb_write(0, 32'd0, 4'h1);
      frame(6, 3, 3, 0, -1);
      frame(6, 3, 3, 0, -1);
      read_all();
      wb_write(0, 32'd3, 4'h1);
      frame(6, 3, 3, 0, -1);
      frame(6, 3, 0, 0, -1);
      read_all();
      frame(6, 3, 3, 0, -1);
      read_all();
      frame(6, 3, 3, 0, 10);
      read_all();
      frame(4, 2, 0, 0, -1);
      read_all();
      frame(4, 2, 3, 0, -1);
      read_all();
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge aclk);
      #1;
      check("stream_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
